// File: rtl/ram_mp_if.sv
// ram_mp_if: request/response bundle for the multi-port RAM.
interface ram_mp_if #(
    parameter int DATAWIDTH = 64,
    parameter int LOGINDEX = 8,
    parameter int NUMRD = 2,
    parameter int NUMWR = 2
);
    logic                          clear_in;
    logic [NUMWR-1:0]              we_in;
    logic [NUMWR*LOGINDEX-1:0]     windex_in;
    logic [NUMWR*DATAWIDTH-1:0]    wdata_in;
    logic [NUMRD-1:0]              ren_in;
    logic [NUMRD*LOGINDEX-1:0]     rindex_in;
    logic [NUMRD*DATAWIDTH-1:0]    rdata_out;
    logic                          collision_out;
    modport master (
        output clear_in, we_in, windex_in, wdata_in, ren_in, rindex_in,
        input  rdata_out, collision_out
    );
    modport slave (
        input  clear_in, we_in, windex_in, wdata_in, ren_in, rindex_in,
        output rdata_out, collision_out
    );
endinterface

// File: rtl/ram_mp.sv
// ram_mp: multi-port RAM with prioritised writes, optional bypass and registered
// read, and single-cycle flash clear through per-entry valid bits.
module ram_mp #(
    parameter int DATAWIDTH = 64,
    parameter int INDEXSIZE = 256,
    parameter int LOGINDEX = 8,
    parameter logic [DATAWIDTH-1:0] INITVALUE = '0,
    parameter int NUMRD = 2,
    parameter int NUMWR = 2,
    parameter int RDREG = 0,
    parameter int BYPASS = 1
) (
    input  logic   clock,
    input  logic   reset,
    ram_mp_if.slave bus
);
    localparam logic [LOGINDEX:0] LIMIT = (LOGINDEX + 1)'(INDEXSIZE);
    logic [DATAWIDTH-1:0]       mem_q [INDEXSIZE];
    logic [DATAWIDTH-1:0]       mem_d [INDEXSIZE];
    logic [INDEXSIZE-1:0]       valid_q, valid_d;
    logic [NUMRD*DATAWIDTH-1:0] rd_v, rdata_d, rdata_q;
    logic                       collision_d, collision_q;
    logic [NUMWR-1:0]           wr_ok;
    logic [LOGINDEX-1:0]        wi [NUMWR];
    logic [DATAWIDTH-1:0]       wd [NUMWR];
    logic [LOGINDEX-1:0]        ri [NUMRD];
    for (genvar p = 0; p < NUMWR; p++) begin : g_w
        assign wi[p]    = bus.windex_in[p*LOGINDEX +: LOGINDEX];
        assign wd[p]    = bus.wdata_in[p*DATAWIDTH +: DATAWIDTH];
        assign wr_ok[p] = bus.we_in[p] && ({1'b0, wi[p]} < LIMIT);
    end
    for (genvar r = 0; r < NUMRD; r++) begin : g_r
        assign ri[r] = bus.rindex_in[r*LOGINDEX +: LOGINDEX];
    end
    // Clear first, then ports in ascending order so the highest port wins.
    always_comb begin
        mem_d = mem_q;
        valid_d = bus.clear_in ? '0 : valid_q;
        collision_d = 1'b0;
        for (int p = 0; p < NUMWR; p++) begin
            if (wr_ok[p]) begin
                mem_d[wi[p]] = wd[p];
                valid_d[wi[p]] = 1'b1;
            end
            for (int q = p + 1; q < NUMWR; q++)
                collision_d = collision_d | (wr_ok[p] && wr_ok[q] && wi[p] == wi[q]);
        end
    end
    always_comb begin
        rd_v = '0;
        rdata_d = rdata_q;
        for (int r = 0; r < NUMRD; r++) begin
            rd_v[r*DATAWIDTH +: DATAWIDTH] =
                ({1'b0, ri[r]} < LIMIT && valid_q[ri[r]]) ? mem_q[ri[r]] : INITVALUE;
            if (BYPASS != 0) begin
                if (bus.clear_in)
                    rd_v[r*DATAWIDTH +: DATAWIDTH] = INITVALUE;
                for (int p = 0; p < NUMWR; p++)
                    if (wr_ok[p] && wi[p] == ri[r])
                        rd_v[r*DATAWIDTH +: DATAWIDTH] = wd[p];
            end
            if (bus.ren_in[r])
                rdata_d[r*DATAWIDTH +: DATAWIDTH] = rd_v[r*DATAWIDTH +: DATAWIDTH];
        end
    end
    // Storage carries no reset; validity alone decides what a read returns.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            rdata_q <= {NUMRD{INITVALUE}};
            collision_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            collision_q <= collision_d;
        end
    end
    assign bus.rdata_out = (RDREG != 0) ? rdata_q : rd_v;
    assign bus.collision_out = collision_q;
endmodule

// File: tb/tb_ram_mp.sv
// tb_ram_mp: drives three ram_mp variants (bypass comb, no-bypass comb,
// bypass registered) with shared stimulus and checks them against a model.
module tb_ram_mp;
    localparam int DW = 16, IS = 200, LI = 8, NR = 2, NW = 2;
    localparam logic [DW-1:0] INIT = 16'hE0E0;
    typedef struct {
        logic clr;
        logic [1:0] we, ren;
        logic [LI-1:0] wi0;
        logic [DW-1:0] wd0;
        logic [LI-1:0] wi1;
        logic [DW-1:0] wd1;
        logic [LI-1:0] ri0, ri1;
        logic [DW-1:0] e0, e1;
        logic ecol;
    } vec_t;
    logic clock = 1'b0, reset = 1'b0;
    logic clr = 1'b0;
    logic [1:0] we = '0, ren = '0;
    logic [LI-1:0] wi0 = '0, wi1 = '0, ri0 = '0, ri1 = '0;
    logic [DW-1:0] wd0 = '0, wd1 = '0;
    always #5 clock = ~clock;
    ram_mp_if #(DW, LI, NR, NW) b0 (), b1 (), b2 ();
    assign b0.clear_in = clr; assign b0.we_in = we; assign b0.ren_in = ren;
    assign b0.windex_in = {wi1, wi0}; assign b0.wdata_in = {wd1, wd0}; assign b0.rindex_in = {ri1, ri0};
    assign b1.clear_in = clr; assign b1.we_in = we; assign b1.ren_in = ren;
    assign b1.windex_in = {wi1, wi0}; assign b1.wdata_in = {wd1, wd0}; assign b1.rindex_in = {ri1, ri0};
    assign b2.clear_in = clr; assign b2.we_in = we; assign b2.ren_in = ren;
    assign b2.windex_in = {wi1, wi0}; assign b2.wdata_in = {wd1, wd0}; assign b2.rindex_in = {ri1, ri0};
    ram_mp #(.DATAWIDTH(DW), .INDEXSIZE(IS), .LOGINDEX(LI), .INITVALUE(INIT), .NUMRD(NR),
             .NUMWR(NW), .RDREG(0), .BYPASS(1)) d0 (.clock(clock), .reset(reset), .bus(b0));
    ram_mp #(.DATAWIDTH(DW), .INDEXSIZE(IS), .LOGINDEX(LI), .INITVALUE(INIT), .NUMRD(NR),
             .NUMWR(NW), .RDREG(0), .BYPASS(0)) d1 (.clock(clock), .reset(reset), .bus(b1));
    ram_mp #(.DATAWIDTH(DW), .INDEXSIZE(IS), .LOGINDEX(LI), .INITVALUE(INIT), .NUMRD(NR),
             .NUMWR(NW), .RDREG(1), .BYPASS(1)) d2 (.clock(clock), .reset(reset), .bus(b2));
    int checks = 0, fails = 0;
    logic [DW-1:0] mem_m [IS];
    logic val_m [IS];
    logic [DW-1:0] reg_m [NR];
    logic col_m;
    logic [DW-1:0] q_pre [$];
    logic [DW-1:0] q_reg [$];
    logic q_col [$];
    vec_t tbl [17];
    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    function automatic logic [DW-1:0] pre(input logic [LI-1:0] i);
        if (int'(i) < IS) begin
            if (val_m[i]) return mem_m[i];
        end
        return INIT;
    endfunction
    function automatic logic [DW-1:0] byp(input logic [LI-1:0] i);
        if (we[1] && wi1 == i && int'(wi1) < IS) return wd1;
        if (we[0] && wi0 == i && int'(wi0) < IS) return wd0;
        if (clr) return INIT;
        return pre(i);
    endfunction
    function automatic void model_reset();
        for (int i = 0; i < IS; i++) val_m[i] = 1'b0;
        for (int r = 0; r < NR; r++) reg_m[r] = INIT;
        col_m = 1'b0;
    endfunction
    function automatic void model_edge();
        col_m = we == 2'b11 && wi0 == wi1 && int'(wi0) < IS;
        if (ren[0]) reg_m[0] = byp(ri0);
        if (ren[1]) reg_m[1] = byp(ri1);
        if (clr) for (int i = 0; i < IS; i++) val_m[i] = 1'b0;
        if (we[0] && int'(wi0) < IS) begin mem_m[wi0] = wd0; val_m[wi0] = 1'b1; end
        if (we[1] && int'(wi1) < IS) begin mem_m[wi1] = wd1; val_m[wi1] = 1'b1; end
    endfunction
    task automatic apply(input vec_t v, input int n);
        logic c;
        @(negedge clock);
        clr = v.clr; we = v.we; ren = v.ren;
        wi0 = v.wi0; wd0 = v.wd0; wi1 = v.wi1; wd1 = v.wd1; ri0 = v.ri0; ri1 = v.ri1;
        q_pre.push_back(pre(ri0));
        q_pre.push_back(pre(ri1));
        model_edge();
        q_reg.push_back(reg_m[0]);
        q_reg.push_back(reg_m[1]);
        q_col.push_back(col_m);
        #2;
        chk($sformatf("v%0d byp p0", n), b0.rdata_out[0 +: DW], v.e0);
        chk($sformatf("v%0d byp p1", n), b0.rdata_out[DW +: DW], v.e1);
        chk($sformatf("v%0d pre p0", n), b1.rdata_out[0 +: DW], q_pre.pop_front());
        chk($sformatf("v%0d pre p1", n), b1.rdata_out[DW +: DW], q_pre.pop_front());
        @(posedge clock);
        #1;
        chk($sformatf("v%0d reg p0", n), b2.rdata_out[0 +: DW], q_reg.pop_front());
        chk($sformatf("v%0d reg p1", n), b2.rdata_out[DW +: DW], q_reg.pop_front());
        c = q_col.pop_front();
        chk($sformatf("v%0d col d0", n), {15'd0, b0.collision_out}, {15'd0, v.ecol});
        chk($sformatf("v%0d col d1", n), {15'd0, b1.collision_out}, {15'd0, c});
        chk($sformatf("v%0d col d2", n), {15'd0, b2.collision_out}, {15'd0, c});
    endtask
    initial begin
        vec_t v;
        logic [LI-1:0] idx [5];
        //        clr   we     ren    wi0   wd0       wi1   wd1       ri0     ri1     e0        e1        col
        tbl[0]  = '{1'b0, 2'b00, 2'b11, 8'd0, 16'h0000, 8'd0, 16'h0000, 8'd5,   8'd5,   INIT,     INIT,     1'b0};
        tbl[1]  = '{1'b0, 2'b01, 2'b11, 8'd3, 16'hAAAA, 8'd0, 16'h0000, 8'd3,   8'd5,   16'hAAAA, INIT,     1'b0};
        tbl[2]  = '{1'b0, 2'b00, 2'b11, 8'd0, 16'h0000, 8'd0, 16'h0000, 8'd3,   8'd3,   16'hAAAA, 16'hAAAA, 1'b0};
        tbl[3]  = '{1'b0, 2'b11, 2'b11, 8'd7, 16'h0011, 8'd7, 16'h0022, 8'd7,   8'd3,   16'h0022, 16'hAAAA, 1'b1};
        tbl[4]  = '{1'b0, 2'b00, 2'b11, 8'd0, 16'h0000, 8'd0, 16'h0000, 8'd7,   8'd7,   16'h0022, 16'h0022, 1'b0};
        tbl[5]  = '{1'b0, 2'b11, 2'b11, 8'd0, 16'h1000, 8'd1, 16'h1001, 8'd0,   8'd1,   16'h1000, 16'h1001, 1'b0};
        tbl[6]  = '{1'b0, 2'b11, 2'b11, 8'd2, 16'h1002, 8'd3, 16'h1003, 8'd3,   8'd2,   16'h1003, 16'h1002, 1'b0};
        tbl[7]  = '{1'b1, 2'b01, 2'b11, 8'd2, 16'h0055, 8'd0, 16'h0000, 8'd2,   8'd0,   16'h0055, INIT,     1'b0};
        tbl[8]  = '{1'b0, 2'b00, 2'b11, 8'd0, 16'h0000, 8'd0, 16'h0000, 8'd0,   8'd1,   INIT,     INIT,     1'b0};
        tbl[9]  = '{1'b0, 2'b00, 2'b11, 8'd0, 16'h0000, 8'd0, 16'h0000, 8'd2,   8'd3,   16'h0055, INIT,     1'b0};
        tbl[10] = '{1'b0, 2'b01, 2'b11, 8'd250, 16'h0001, 8'd0, 16'h0000, 8'd250, 8'd7,   INIT,     INIT,     1'b0};
        tbl[11] = '{1'b0, 2'b11, 2'b11, 8'd250, 16'h0001, 8'd250, 16'h0002, 8'd250, 8'd250, INIT,   INIT,     1'b0};
        tbl[12] = '{1'b0, 2'b01, 2'b11, 8'd199, 16'hABCD, 8'd0, 16'h0000, 8'd199, 8'd200, 16'hABCD, INIT,   1'b0};
        tbl[13] = '{1'b0, 2'b10, 2'b11, 8'd0, 16'h0000, 8'd1, 16'h0099, 8'd1,   8'd1,   16'h0099, 16'h0099, 1'b0};
        tbl[14] = '{1'b0, 2'b01, 2'b00, 8'd1, 16'h0077, 8'd0, 16'h0000, 8'd1,   8'd1,   16'h0077, 16'h0077, 1'b0};
        tbl[15] = '{1'b0, 2'b00, 2'b01, 8'd0, 16'h0000, 8'd0, 16'h0000, 8'd1,   8'd1,   16'h0077, 16'h0077, 1'b0};
        tbl[16] = '{1'b0, 2'b00, 2'b11, 8'd0, 16'h0000, 8'd0, 16'h0000, 8'd1,   8'd1,   16'h0077, 16'h0077, 1'b0};
        model_reset();
        #1 reset = 1'b1;
        #1;
        chk("rst reg p0", b2.rdata_out[0 +: DW], INIT);
        chk("rst reg p1", b2.rdata_out[DW +: DW], INIT);
        chk("rst col", {15'd0, b2.collision_out}, 16'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 17; i++) apply(tbl[i], i);
        v = '{1'b0, 2'b11, 2'b11, 8'd10, 16'h1234, 8'd11, 16'h5678, 8'd10, 8'd11, 16'h1234, 16'h5678, 1'b0};
        apply(v, 17);
        // Reset lands in the middle of a colliding write cycle.
        @(negedge clock);
        we = 2'b11; wi0 = 8'd12; wd0 = 16'h4321; wi1 = 8'd12; wd1 = 16'h9999;
        ren = 2'b11; ri0 = 8'd12; ri1 = 8'd10;
        #2 reset = 1'b1;
        #1;
        chk("mid rst byp hit", b0.rdata_out[0 +: DW], 16'h9999);
        chk("mid rst byp inv", b0.rdata_out[DW +: DW], INIT);
        chk("mid rst pre p1", b1.rdata_out[DW +: DW], INIT);
        chk("mid rst reg p0", b2.rdata_out[0 +: DW], INIT);
        @(posedge clock);
        #1;
        chk("mid rst col", {15'd0, b0.collision_out}, 16'd0);
        chk("mid rst reg p1", b2.rdata_out[DW +: DW], INIT);
        @(negedge clock);
        reset = 1'b0; we = 2'b00;
        model_reset();
        idx = '{8'd10, 8'd11, 8'd12, 8'd5, 8'd199};
        for (int i = 0; i < 5; i++) begin
            v = '{1'b0, 2'b00, 2'b11, 8'd0, 16'h0, 8'd0, 16'h0, idx[i], idx[i], INIT, INIT, 1'b0};
            apply(v, 18 + i);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/ram_mp.md
# ram_mp

Parametrised multi-port RAM for core-side tables and register files, the next generation of the dual-port table RAM. It adds:
- configurable read and write port counts;
- deterministic priority between write ports;
- an optional same-cycle write-to-read bypass;
- an optional registered read stage;
- a single-cycle flash clear through per-entry valid bits.

Used for rename maps, predictor tables and scoreboards, where the whole table must be invalidated on flush without a per-entry reset of the storage array.

## Interface
- DATAWIDTH, 64: entry width in bits
- INDEXSIZE, 256: number of entries
- LOGINDEX, 8: index width; INDEXSIZE <= 2**LOGINDEX
- INITVALUE, 0: value returned for any invalid entry
- NUMRD, 2: read ports
- NUMWR, 2: write ports
- RDREG, 0: 0 = combinational read, 1 = registered read (1-cycle latency)
- BYPASS, 1: 1 = reads return the post-edge state, 0 = reads return the pre-edge state
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; clears valid vector, output registers, collision_out
- clear_in  in  1  flash clear; invalidates all entries at the next posedge
- we_in  in  NUMWR  per-port write enable
- windex_in  in  NUMWR*LOGINDEX  write indices; port p at bits [p*LOGINDEX +: LOGINDEX]
- wdata_in  in  NUMWR*DATAWIDTH  write data; port p at bits [p*DATAWIDTH +: DATAWIDTH]
- ren_in  in  NUMRD  read-register load enable; used only when RDREG=1
- rindex_in  in  NUMRD*LOGINDEX  read indices, packed as above
- rdata_out  out  NUMRD*DATAWIDTH  read data, packed as above
- collision_out  out  1  registered; high one cycle after any two enabled write ports targeted the same index

## Operation
- Storage: mem[INDEXSIZE] holds data and is not reset. valid[INDEXSIZE] is reset to all zero.
- Invalid entry: any read of an entry with valid=0 returns INITVALUE.
- Write, at posedge: for each port p with we_in[p] and windex_p < INDEXSIZE, set mem[windex_p] <= wdata_p and valid[windex_p] <= 1.
- Same-index writes: when several enabled ports target the same index, the highest-numbered port wins.
- Out of range: writes with windex >= INDEXSIZE are dropped. Reads with rindex >= INDEXSIZE return INITVALUE.
- clear_in, at posedge: all valid bits <= 0.
- clear_in plus a write in the same cycle: the write is applied after the clear. The written entry ends valid with the new data; all others end invalid.
- Read value v(r), BYPASS=1, first match wins:
  1. an enabled, in-range write port hits rindex_r: data of the highest-numbered such port;
  2. else if clear_in: INITVALUE;
  3. else if valid: mem;
  4. else INITVALUE.
- Read value v(r), BYPASS=0: valid ? mem[rindex_r] : INITVALUE, using pre-edge state only.
- RDREG=0: rdata_out[r] = v(r), combinational from the current inputs and state.
- RDREG=1: at posedge, if ren_in[r], rdata_out[r] <= v(r); otherwise it holds.
- collision_out, at posedge: collision_out <= OR over all port pairs p<q of (we_p & we_q & windex_p == windex_q & index in range). It is a sticky-free one-cycle flag per colliding cycle.

## Timing
- Reset asserted: asynchronously, valid = 0, collision_out = 0, and rdata_out registers (RDREG=1) = INITVALUE.
- Reset, RDREG=0: rdata_out = INITVALUE for every port unless BYPASS=1 and a write hits that port's index.
- Reset mid-write: the write in flight is lost. After release, every entry reads INITVALUE.
- Write-to-read, BYPASS=1: 0 cycles combinational (RDREG=0); visible on rdata_out after the same edge (RDREG=1).
- Write-to-read, BYPASS=0: the new data is visible to combinational reads in the cycle after the edge.
- Clear latency: one edge. With BYPASS=1 a read in the clear cycle already returns INITVALUE.
- Ordering: no ordering assumptions between ports. All ports update on the same edge.
- Throughput: every port accepts a new request every cycle.

## Test plan
- Reset with RDREG=1, then read index 5 on both ports -> rdata_out = INITVALUE (0) on both; collision_out = 0.
- Write port0 idx 3 = 0xAAAA in cycle N, read idx 3 -> BYPASS=1, RDREG=0: 0xAAAA in cycle N. BYPASS=0: INITVALUE in N, 0xAAAA in N+1.
- Ports 0 and 1 both write idx 7 (0x11, 0x22) -> mem[7] = 0x22; collision_out = 1 for exactly one cycle after the edge. Different indices -> collision_out stays 0.
- Fill idx 0..3, then pulse clear_in together with a port0 write idx 2 = 0x55 -> afterwards idx 0, 1, 3 read 0 and idx 2 reads 0x55.
- RDREG=1: load rdata_out with ren_in=1 for idx 1 = 0x99, drop ren_in, then write idx 1 = 0x77 -> rdata_out holds 0x99 until ren_in reasserts, then 0x77.
- INDEXSIZE=200, LOGINDEX=8: write idx 250 = 0x1 -> no entry is modified; read idx 250 returns INITVALUE. Assert reset mid-sequence -> all reads return INITVALUE after release.
